bitplane_streamer: RTL
======================

BITPLANE_STREAMER -- requirements
Module: bitplane_streamer

Interface
REQ-001 SHALL have parameter LANES, default 16: number of lanes, which is also the plane width.
REQ-002 SHALL have parameter BITS, default 8: bits per lane element, which is also the plane count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream offers a matrix.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can capture a matrix this cycle.
REQ-007 SHALL have port in_matrix, input, LANES*BITS bits: bit-plane matrix; row r occupies bits [r*LANES +: LANES] and holds bit (BITS-1-r) of every lane.
REQ-008 SHALL have port out_valid, output, 1 bit: a plane is presented.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the presented plane.
REQ-010 SHALL have port out_plane, output, LANES bits: current plane data.
REQ-011 SHALL have port out_idx, output, $clog2(BITS) bits: bit position of the current plane.
REQ-012 SHALL have port out_last, output, 1 bit: the current plane is the final plane of the matrix.

Function
REQ-013 SHALL implement FSM states IDLE and STREAM; in_ready SHALL be 1 in IDLE, and SHALL also be 1 in STREAM in any cycle where out_valid & out_ready & out_last.
REQ-014 SHALL capture in_matrix into an internal register on each edge where in_valid & in_ready, then enter or stay in STREAM.
REQ-015 SHALL assert out_valid on the cycle after capture; latency is 1 cycle.
REQ-016 SHALL emit planes MSB-first: out_idx = BITS-1 down to 0, with plane j = captured[(BITS-1-j)*LANES +: LANES].
REQ-017 SHALL advance to the next plane only on a cycle with out_valid & out_ready.
REQ-018 SHALL hold out_plane, out_idx and out_last stable while out_valid & !out_ready.
REQ-019 SHALL, when the last plane is accepted with no new capture on that edge, return to IDLE and deassert out_valid on the next cycle.
REQ-020 SHALL, when the last plane is accepted and a new capture occurs on the same edge, present the first plane of the new matrix on the next cycle with no bubble; throughput is one plane per cycle.
REQ-021 SHALL have every output (out_plane, out_idx, out_last, out_valid) registered; in_ready is decoded combinationally from state and the handshake.

Reset
REQ-022 SHALL, while rst=1, force state=IDLE, out_valid=0, out_plane=0, out_idx=0, out_last=0, in_ready=0, and clear the capture register.
REQ-023 SHALL, when rst is asserted mid-stream, discard the in-flight matrix; no further planes of that matrix appear after reset.
REQ-024 SHALL drive in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with macro BITPLANE_ZERO_SKIP_EN defined, compute a nonzero-plane mask at capture and emit only the nonzero planes, still MSB-first; out_last SHALL mark the lowest-index nonzero plane.
REQ-026 SHALL, with BITPLANE_ZERO_SKIP_EN defined and an all-zero matrix captured, emit exactly one plane: out_idx=0, out_plane=0, out_last=1.
REQ-027 SHALL, without BITPLANE_ZERO_SKIP_EN, always emit all BITS planes, with out_last on out_idx=0.

Structure
REQ-028 SHALL take LANES, BITS, the plane index typedef and the FSM state enum from the shared package sparse_pkg.
REQ-029 SHALL place next-nonzero-plane selection in sub-module plane_prio_enc, a combinational priority encoder over the mask below the current index; it is instantiated only when BITPLANE_ZERO_SKIP_EN is defined.

Verification
REQ-030 SHALL cover streaming with out_ready held 1: lanes = 0x00..0x0F (lane i = i), skip off -> 8 planes; idx 7..4 planes = 0x0000; idx3 = 0xFF00; idx2 = 0xF0F0; idx1 = 0xCCCC; idx0 = 0xAAAA with last=1.
REQ-031 SHALL cover back-pressure: toggle out_ready 1,0,0,1 on the plane at idx 5 -> the plane and idx are held across the stall, with no loss or duplication.
REQ-032 SHALL cover back-to-back matrices: in_valid held high with two matrices -> 16 consecutive out_valid cycles, and the second capture occurs on the same edge as the first out_last.
REQ-033 SHALL cover zero skip: with BITPLANE_ZERO_SKIP_EN, all lanes = 0x05 -> planes idx2 = 0xFFFF then idx0 = 0xFFFF with last=1; all lanes = 0x00 -> one plane, idx0 = 0x0000 with last=1.
REQ-034 SHALL cover reset mid-stream: rst pulsed at the idx4 plane -> out_valid=0 the next cycle, then in_ready=1, and the next matrix streams from idx 7.

Source files
------------

// File: rtl/sparse_pkg.sv
// Shared types and default geometry for the bit-plane streamer.
package sparse_pkg;
  localparam int LANES = 16;
  localparam int BITS  = 8;
  localparam int IDX_W = $clog2(BITS);

  typedef logic [IDX_W-1:0] plane_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/plane_prio_enc.sv
// Combinational priority encoder: highest set mask bit strictly below limit,
// plus whether any set bit remains below the one it selects.
module plane_prio_enc #(
  parameter int BITS = sparse_pkg::BITS
) (
  input  logic [BITS-1:0]         mask,
  input  logic [$clog2(BITS):0]   limit,
  output logic                    found,
  output sparse_pkg::plane_idx_t  idx,
  output logic                    more
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    more  = 1'b0;
    // Ascending scan: the last hit is the highest qualifying bit.
    for (int j = 0; j < BITS; j++) begin
      if (j < int'(limit) && mask[j]) begin
        found = 1'b1;
        idx   = sparse_pkg::plane_idx_t'(j);
      end
    end
    for (int j = 0; j < BITS; j++) begin
      if (found && j < int'(idx) && mask[j]) more = 1'b1;
    end
  end
endmodule

// File: rtl/bitplane_streamer.sv
// Captures a bit-plane matrix and streams its planes MSB-first over valid/ready.
// Optional zero-plane skipping is enabled by defining BITPLANE_ZERO_SKIP_EN.
module bitplane_streamer #(
  parameter int LANES = sparse_pkg::LANES,
  parameter int BITS  = sparse_pkg::BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*BITS-1:0]    in_matrix,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_plane,
  output sparse_pkg::plane_idx_t   out_idx,
  output logic                     out_last,
  output sparse_pkg::state_t       fsm_state
);
  import sparse_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; out_* stay constant while out_valid is high and out_ready is low.

  state_t                  state_q, state_d;
  logic [LANES*BITS-1:0]   cap_q;
  logic                    out_valid_q, out_last_q;
  logic [LANES-1:0]        out_plane_q;
  plane_idx_t              out_idx_q;

  logic                    capture, accept, final_accept;
  plane_idx_t              first_idx, next_idx;
  logic                    first_last, next_last;

  assign accept       = out_valid_q && out_ready;
  assign final_accept = accept && out_last_q;
  assign in_ready     = !rst && (state_q == IDLE || final_accept);
  assign capture      = in_valid && in_ready;

`ifdef BITPLANE_ZERO_SKIP_EN
  logic [BITS-1:0] in_mask, mask_q;
  logic            cap_found, cap_more, adv_found, adv_more;
  plane_idx_t      cap_idx, adv_idx;

  always_comb begin
    in_mask = '0;
    for (int j = 0; j < BITS; j++) begin
      in_mask[j] = |in_matrix[(BITS-1-j)*LANES +: LANES];
    end
  end

  plane_prio_enc #(.BITS(BITS)) u_cap_enc (
    .mask  (in_mask),
    .limit ((IDX_W+1)'(BITS)),
    .found (cap_found),
    .idx   (cap_idx),
    .more  (cap_more)
  );

  plane_prio_enc #(.BITS(BITS)) u_adv_enc (
    .mask  (mask_q),
    .limit ({1'b0, out_idx_q}),
    .found (adv_found),
    .idx   (adv_idx),
    .more  (adv_more)
  );

  // An all-zero matrix still yields one plane: index 0, data 0, last.
  always_comb begin
    first_idx  = cap_found ? cap_idx : '0;
    first_last = !cap_more;
    next_idx   = adv_found ? adv_idx : '0;
    next_last  = !adv_more;
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else if (capture) mask_q <= in_mask;
  end
`else
  always_comb begin
    first_idx  = plane_idx_t'(BITS-1);
    first_last = (BITS == 1);
    next_idx   = out_idx_q - 1'b1;
    next_last  = (out_idx_q == plane_idx_t'(1));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = STREAM;
      STREAM:  if (final_accept && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q       <= '0;
      out_valid_q <= 1'b0;
      out_plane_q <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (capture) begin
      cap_q       <= in_matrix;
      out_valid_q <= 1'b1;
      out_idx_q   <= first_idx;
      out_last_q  <= first_last;
      out_plane_q <= in_matrix[(BITS-1-int'(first_idx))*LANES +: LANES];
    end else if (accept) begin
      if (out_last_q) begin
        out_valid_q <= 1'b0;
      end else begin
        out_idx_q   <= next_idx;
        out_last_q  <= next_last;
        out_plane_q <= cap_q[(BITS-1-int'(next_idx))*LANES +: LANES];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_plane = out_plane_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign fsm_state = state_q;
endmodule
